// File: rtl/updn_pkg.sv
// rtl/updn_pkg.sv - shared constants and helpers for the updn_counter family
package updn_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // MODULUS is carried as longint so that MODULUS = 2^32 with WIDTH = 32 stays representable.
  function automatic logic [31:0] term_val(input int width, input longint modulus);
    longint mask;
    mask = (longint'(1) << width) - longint'(1);
    return 32'((modulus - longint'(1)) & mask);
  endfunction

  function automatic logic [31:0] clamp_load(input logic [31:0] d, input longint modulus);
    if (longint'({32'b0, d}) < modulus)
      return d;
    else
      return 32'(modulus - longint'(1));
  endfunction

endpackage

// File: rtl/updn_counter.sv
// rtl/updn_counter.sv - cascadable modulo up/down counter with load, carry/borrow and wrap pulse
// Optional UPDN_SATURATE_EN: hold at the terminal value instead of wrapping.
module updn_counter
  import updn_pkg::*;
#(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic             clk,
  input  logic             nclr,
  input  logic             nload,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  input  logic             down,
  input  logic             cin,
  output logic [WIDTH-1:0] out,
  output logic             co,
  output logic             bo,
  output logic             wrap,
  output logic             dir
);

  localparam logic [WIDTH-1:0] TERM = WIDTH'(term_val(WIDTH, MODULUS));

  logic             at_term;
  logic             at_zero;
  logic             take;
  logic [WIDTH-1:0] load_val;

  assign at_term  = (out == TERM);
  assign at_zero  = (out == '0);
  assign take     = cin & (up ^ down);
  assign load_val = WIDTH'(clamp_load(32'(d), MODULUS));

  assign co = at_term & up & ~down & cin;
  assign bo = at_zero & down & ~up & cin;

  always_ff @(posedge clk) begin
    if (!nclr) begin
      out  <= '0;
      wrap <= 1'b0;
      dir  <= DIR_UP;
    end else if (!nload) begin
      out  <= load_val;
      wrap <= 1'b0;
    end else if (take) begin
      // co/bo already qualify the terminal edge with direction and cin
      wrap <= co | bo;
      if (up) begin
        dir <= DIR_UP;
`ifdef UPDN_SATURATE_EN
        if (!at_term) out <= out + WIDTH'(1);
`else
        out <= at_term ? '0 : out + WIDTH'(1);
`endif
      end else begin
        dir <= DIR_DN;
`ifdef UPDN_SATURATE_EN
        if (!at_zero) out <= out - WIDTH'(1);
`else
        out <= at_zero ? TERM : out - WIDTH'(1);
`endif
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updn_counter.sv
// tb/tb_updn_counter.sv - self-checking bench for updn_counter (binary, decade and two-stage cascade)
module tb_updn_counter;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_nclr, a_nload, a_up, a_down, a_cin;
  logic [3:0] a_d, a_out;
  logic       a_co, a_bo, a_wrap, a_dir;

  logic       b_nclr, b_nload, b_up, b_down, b_cin;
  logic [3:0] b_d, b_out;
  logic       b_co, b_bo, b_wrap, b_dir;

  logic       c_nclr, c_nload, c_up, c_down;
  logic [3:0] c_d0, c_d1, c0_out, c1_out;
  logic       c0_co, c0_bo, c0_wrap, c0_dir;
  logic       c1_co, c1_bo, c1_wrap, c1_dir;
  logic       c1_cin;
  logic       one;

  assign one    = 1'b1;
  assign c1_cin = c0_co | c0_bo;

  updn_counter #(.WIDTH(4), .MODULUS(16)) u_a (
    .clk(clk), .nclr(a_nclr), .nload(a_nload), .d(a_d), .up(a_up), .down(a_down), .cin(a_cin),
    .out(a_out), .co(a_co), .bo(a_bo), .wrap(a_wrap), .dir(a_dir));

  updn_counter #(.WIDTH(4), .MODULUS(10)) u_b (
    .clk(clk), .nclr(b_nclr), .nload(b_nload), .d(b_d), .up(b_up), .down(b_down), .cin(b_cin),
    .out(b_out), .co(b_co), .bo(b_bo), .wrap(b_wrap), .dir(b_dir));

  updn_counter #(.WIDTH(4), .MODULUS(10)) u_c0 (
    .clk(clk), .nclr(c_nclr), .nload(c_nload), .d(c_d0), .up(c_up), .down(c_down), .cin(one),
    .out(c0_out), .co(c0_co), .bo(c0_bo), .wrap(c0_wrap), .dir(c0_dir));

  updn_counter #(.WIDTH(4), .MODULUS(10)) u_c1 (
    .clk(clk), .nclr(c_nclr), .nload(c_nload), .d(c_d1), .up(c_up), .down(c_down), .cin(c1_cin),
    .out(c1_out), .co(c1_co), .bo(c1_bo), .wrap(c1_wrap), .dir(c1_dir));

  int checks = 0;
  int errors = 0;

  typedef struct {
    int v;
    bit w;
    bit dr;
  } ms_t;

  ms_t ma  = '{0, 1'b0, 1'b1};
  ms_t mb  = '{0, 1'b0, 1'b1};
  ms_t mc0 = '{0, 1'b0, 1'b1};
  ms_t mc1 = '{0, 1'b0, 1'b1};

  // Reference digit: plain integer arithmetic on the value range 0..mod-1.
  function automatic ms_t mnext(ms_t s, int mod, bit nclr, bit nload, int d, bit up, bit down, bit cin);
    ms_t n;
    n = s;
    if (!nclr) begin
      n.v = 0; n.w = 1'b0; n.dr = 1'b1;
    end else if (!nload) begin
      n.v = (d < mod) ? d : mod - 1;
      n.w = 1'b0;
    end else if (cin && (up != down)) begin
      if (up) begin
        n.dr = 1'b1;
        n.w  = (s.v == mod - 1);
`ifdef UPDN_SATURATE_EN
        n.v  = (s.v + 1 > mod - 1) ? mod - 1 : s.v + 1;
`else
        n.v  = (s.v + 1) % mod;
`endif
      end else begin
        n.dr = 1'b0;
        n.w  = (s.v == 0);
`ifdef UPDN_SATURATE_EN
        n.v  = (s.v - 1 < 0) ? 0 : s.v - 1;
`else
        n.v  = (s.v + mod - 1) % mod;
`endif
      end
    end else begin
      n.w = 1'b0;
    end
    return n;
  endfunction

  function automatic bit mco(ms_t s, int mod, bit up, bit down, bit cin);
    return (s.v == mod - 1) && up && !down && cin;
  endfunction

  function automatic bit mbo(ms_t s, bit up, bit down, bit cin);
    return (s.v == 0) && down && !up && cin;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    ms_t na, nb, nc0, nc1;
    bit  cin1;
    na   = mnext(ma, 16, a_nclr, a_nload, int'(a_d), a_up, a_down, a_cin);
    nb   = mnext(mb, 10, b_nclr, b_nload, int'(b_d), b_up, b_down, b_cin);
    nc0  = mnext(mc0, 10, c_nclr, c_nload, int'(c_d0), c_up, c_down, 1'b1);
    cin1 = mco(mc0, 10, c_up, c_down, 1'b1) | mbo(mc0, c_up, c_down, 1'b1);
    nc1  = mnext(mc1, 10, c_nclr, c_nload, int'(c_d1), c_up, c_down, cin1);
    @(posedge clk);
    #1;
    ma = na; mb = nb; mc0 = nc0; mc1 = nc1;
    chk("a_out", a_out, ma.v);
    chk("a_wrap", a_wrap, ma.w);
    chk("a_dir", a_dir, ma.dr);
    chk("a_co", a_co, mco(ma, 16, a_up, a_down, a_cin));
    chk("a_bo", a_bo, mbo(ma, a_up, a_down, a_cin));
    chk("b_out", b_out, mb.v);
    chk("b_wrap", b_wrap, mb.w);
    chk("b_dir", b_dir, mb.dr);
    chk("b_co", b_co, mco(mb, 10, b_up, b_down, b_cin));
    chk("b_bo", b_bo, mbo(mb, b_up, b_down, b_cin));
    chk("c0_out", c0_out, mc0.v);
    chk("c1_out", c1_out, mc1.v);
    chk("c0_wrap", c0_wrap, mc0.w);
    chk("c1_wrap", c1_wrap, mc1.w);
    chk("c1_dir", c1_dir, mc1.dr);
  endtask

  initial begin
    a_nclr = 1'b0; a_nload = 1'b1; a_d = 4'd0; a_up = 1'b0; a_down = 1'b1; a_cin = 1'b1;
    b_nclr = 1'b0; b_nload = 1'b1; b_d = 4'd0; b_up = 1'b0; b_down = 1'b0; b_cin = 1'b1;
    c_nclr = 1'b0; c_nload = 1'b1; c_d0 = 4'd0; c_d1 = 4'd0; c_up = 1'b0; c_down = 1'b0;

    step();
    chk("a_rst_out", a_out, 0);
    chk("a_rst_wrap", a_wrap, 0);
    chk("a_rst_dir", a_dir, 1);
    chk("a_rst_bo", a_bo, 1);

    a_nclr = 1'b1; b_nclr = 1'b1; c_nclr = 1'b1;
    a_nload = 1'b0; a_d = 4'b1111; a_up = 1'b1; a_down = 1'b0;
    step();
    chk("a_load15_out", a_out, 15);
    chk("a_load15_co", a_co, 1);

    a_nclr = 1'b0; a_nload = 1'b1;
    step();
    a_nclr = 1'b1;
    for (int i = 0; i < 16; i++) step();
`ifdef UPDN_SATURATE_EN
    chk("a_up16_out", a_out, 15);
`else
    chk("a_up16_out", a_out, 0);
`endif
    chk("a_up16_wrap", a_wrap, 1);
    chk("a_up16_dir", a_dir, 1);

    a_nclr = 1'b0;
    step();
    a_nclr = 1'b1; a_up = 1'b0; a_down = 1'b1;
    step();
`ifdef UPDN_SATURATE_EN
    chk("a_dn1_out", a_out, 0);
`else
    chk("a_dn1_out", a_out, 15);
`endif
    chk("a_dn1_wrap", a_wrap, 1);
    for (int i = 1; i < 16; i++) step();
    chk("a_dn16_out", a_out, 0);
    chk("a_dn16_bo", a_bo, 1);
    chk("a_dn16_dir", a_dir, 0);

    b_nload = 1'b0; b_d = 4'd12;
    step();
    chk("b_clamp", b_out, 9);
    b_nload = 1'b1; b_up = 1'b1;
    step();
`ifdef UPDN_SATURATE_EN
    chk("b_up_out", b_out, 9);
`else
    chk("b_up_out", b_out, 0);
`endif
    chk("b_up_wrap", b_wrap, 1);
    b_up = 1'b0; b_down = 1'b1;
    step();
`ifdef UPDN_SATURATE_EN
    chk("b_dn_out", b_out, 8);
`else
    chk("b_dn_out", b_out, 9);
`endif

    b_nload = 1'b0; b_d = 4'd5; b_down = 1'b0;
    step();
    b_nload = 1'b1; b_up = 1'b1; b_down = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("b_both_out", b_out, 5);
    chk("b_both_co", b_co, 0);
    chk("b_both_bo", b_bo, 0);
    b_nclr = 1'b0; b_nload = 1'b0; b_d = 4'd7;
    step();
    chk("b_clr_over_load", b_out, 0);
    b_nclr = 1'b1; b_nload = 1'b1; b_up = 1'b0; b_down = 1'b0;

    c_up = 1'b1;
    for (int i = 0; i < 25; i++) step();
`ifdef UPDN_SATURATE_EN
    chk("c_up25", {c1_out, c0_out}, 8'h99);
`else
    chk("c_up25", {c1_out, c0_out}, 8'h25);
`endif
    c_up = 1'b0; c_nload = 1'b0; c_d1 = 4'd2; c_d0 = 4'd5;
    step();
    chk("c_load25", {c1_out, c0_out}, 8'h25);
    c_nload = 1'b1; c_down = 1'b1;
    for (int i = 0; i < 26; i++) step();
`ifdef UPDN_SATURATE_EN
    chk("c_dn26", {c1_out, c0_out}, 8'h00);
    chk("c_dn26_bo", c0_bo, 1);
`else
    chk("c_dn26", {c1_out, c0_out}, 8'h99);
`endif

    for (int i = 0; i < 400; i++) begin
      a_nclr  = ($urandom_range(0, 31) != 0);
      a_nload = ($urandom_range(0, 7) != 0);
      a_d     = 4'($urandom);
      a_up    = 1'($urandom);
      a_down  = 1'($urandom);
      a_cin   = ($urandom_range(0, 3) != 0);
      b_nclr  = ($urandom_range(0, 31) != 0);
      b_nload = ($urandom_range(0, 7) != 0);
      b_d     = 4'($urandom);
      b_up    = 1'($urandom);
      b_down  = 1'($urandom);
      b_cin   = ($urandom_range(0, 3) != 0);
      c_nclr  = ($urandom_range(0, 63) != 0);
      c_nload = ($urandom_range(0, 15) != 0);
      c_d0    = 4'($urandom);
      c_d1    = 4'($urandom);
      c_up    = 1'($urandom);
      c_down  = 1'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
